// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment frame decoder: FSM state codes,
// glyph constants ({g,f,e,d,c,b,a}, active-high) and the glyph->nibble decoder.
package seg7_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CAP_LO = 2'd1;
  localparam logic [1:0] ST_CAP_HI = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] BLANK   = 7'h00;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } glyph_dec_t;

  // A blank digit is a legal zero; anything unrecognised decodes to an illegal zero.
  function automatic glyph_dec_t decode_glyph(input logic [6:0] g);
    glyph_dec_t d;
    d.legal  = 1'b1;
    d.nibble = 4'h0;
    case (g)
      GLYPH_0, BLANK: d.nibble = 4'h0;
      GLYPH_1: d.nibble = 4'h1;
      GLYPH_2: d.nibble = 4'h2;
      GLYPH_3: d.nibble = 4'h3;
      GLYPH_4: d.nibble = 4'h4;
      GLYPH_5: d.nibble = 4'h5;
      GLYPH_6: d.nibble = 4'h6;
      GLYPH_7: d.nibble = 4'h7;
      GLYPH_8: d.nibble = 4'h8;
      GLYPH_9: d.nibble = 4'h9;
      GLYPH_A: d.nibble = 4'hA;
      GLYPH_B: d.nibble = 4'hB;
      GLYPH_C: d.nibble = 4'hC;
      GLYPH_D: d.nibble = 4'hD;
      GLYPH_E: d.nibble = 4'hE;
      GLYPH_F: d.nibble = 4'hF;
      default: d.legal  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_frame_decoder_if.sv
// Display-pin and frame-handshake bundle of the seven-segment frame decoder.
// The decoder uses the slave modport; the pin driver / frame consumer uses master.
interface seg7_frame_decoder_if;
  logic [6:0] seg_in;
  logic       digit_in;
  logic       sync_in;
  logic       flag_in;
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] frame_data;
  logic       frame_flag;
  logic       frame_bad;
  logic       overrun;
  logic       timeout;

  modport slave (
    input  seg_in, digit_in, sync_in, flag_in, frame_ready,
    output frame_valid, frame_data, frame_flag, frame_bad, overrun, timeout
  );

  modport master (
    output seg_in, digit_in, sync_in, flag_in, frame_ready,
    input  frame_valid, frame_data, frame_flag, frame_bad, overrun, timeout
  );
endinterface

// File: rtl/seg7_input_filter.sv
// Pin synchronizer plus stability filter for {seg,digit}; also detects sync rises.
// With SEG7_ACTIVE_LOW_EN defined the segment pins are inverted after synchronizing.
module seg7_input_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       digit_in,
  input  logic       sync_in,
  input  logic       flag_in,
  output logic [6:0] seg,
  output logic       digit,
  output logic       flag,
  output logic       sync_rise,
  output logic       stable
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Bit layout of one pin sample: {flag, sync, digit, seg[6:0]}.
  logic [SYNC_STAGES-1:0][9:0] pin_p0;
  logic [9:0]                  pin_s;
  logic [6:0]                  seg_s;
  logic                        sync_d_p1;
  logic [7:0]                  cand_p1;
  logic [CW-1:0]               cnt_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign pin_s = pin_p0[SYNC_STAGES-1];
`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_s = ~pin_s[6:0];
`else
  assign seg_s = pin_s[6:0];
`endif

  // p0: synchronizer chain
  // p1: edge detect and stability counter on the synchronized samples
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_p0    <= '0;
      sync_d_p1 <= 1'b0;
      cand_p1   <= '0;
      cnt_p1    <= '0;
    end else begin
      pin_p0    <= {pin_p0[SYNC_STAGES-2:0], {flag_in, sync_in, digit_in, seg_in}};
      sync_d_p1 <= pin_s[8];
      if ({seg_s, pin_s[7]} != cand_p1) begin
        cand_p1 <= {seg_s, pin_s[7]};
        cnt_p1  <= '0;
      end else begin
        cnt_p1  <= sat_inc(cnt_p1);
      end
    end
  end

  assign sync_rise = pin_s[8] & ~sync_d_p1;
  assign seg       = cand_p1[7:1];
  assign digit     = cand_p1[0];
  assign flag      = pin_s[9];
  assign stable    = (cnt_p1 == CNT_MAX);

endmodule

// File: rtl/seg7_frame_decoder.sv
// Recovers one {hi,lo} hex byte per sync frame from the multiplexed 7-segment bus.
// Build option: define SEG7_ACTIVE_LOW_EN for a common-anode (active-low) panel.
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst,
  seg7_frame_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [6:0]  seg;
  logic        digit;
  logic        flag;
  logic        sync_rise;
  logic        stable;
  glyph_dec_t  dec;
  logic [1:0]  state;
  logic [TW-1:0] tcnt;
  logic [3:0]  lo_nib;
  logic        lo_bad;
  logic [7:0]  data_r;
  logic        flag_r;
  logic        bad_r;
  logic        ovr_r;
  logic        tmo_r;

  seg7_input_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .seg_in   (bus.seg_in),
    .digit_in (bus.digit_in),
    .sync_in  (bus.sync_in),
    .flag_in  (bus.flag_in),
    .seg      (seg),
    .digit    (digit),
    .flag     (flag),
    .sync_rise(sync_rise),
    .stable   (stable)
  );

  assign dec = decode_glyph(seg);

  // Frame FSM; output registers only load on the high-digit acceptance so a held
  // frame never changes underneath the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      tcnt   <= '0;
      lo_nib <= '0;
      lo_bad <= 1'b0;
      data_r <= '0;
      flag_r <= 1'b0;
      bad_r  <= 1'b0;
      ovr_r  <= 1'b0;
      tmo_r  <= 1'b0;
    end else begin
      tmo_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sync_rise) begin
            state <= ST_CAP_LO;
            tcnt  <= '0;
          end
        end
        ST_CAP_LO, ST_CAP_HI: begin
          if (sync_rise) begin
            state <= ST_CAP_LO;
            tcnt  <= '0;
          end else if (tcnt == TMO_LAST) begin
            state <= ST_IDLE;
            tmo_r <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (stable && !digit && state == ST_CAP_LO) begin
              lo_nib <= dec.nibble;
              lo_bad <= ~dec.legal;
              state  <= ST_CAP_HI;
            end
            if (stable && digit && state == ST_CAP_HI) begin
              data_r <= {dec.nibble, lo_nib};
              bad_r  <= lo_bad | ~dec.legal;
              flag_r <= flag;
              state  <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.frame_ready) begin
            state <= sync_rise ? ST_CAP_LO : ST_IDLE;
            tcnt  <= '0;
          end else if (sync_rise) begin
            ovr_r <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.frame_valid = (state == ST_HOLD);
  assign bus.frame_data  = data_r;
  assign bus.frame_flag  = flag_r;
  assign bus.frame_bad   = bad_r;
  assign bus.overrun     = ovr_r;
  assign bus.timeout     = tmo_r;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Scoreboard bench for seg7_frame_decoder: random and directed frames are modelled
// from the glyph table, queued, and compared by an independent handshake monitor.
module tb_seg7_frame_decoder;

  localparam int STABLE_CYCLES  = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef struct {
    logic [7:0] data;
    logic       flag;
    logic       bad;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg7_frame_decoder_if bus();

  seg7_frame_decoder #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_tmo = 0;
  bit   rdy_force = 1'b0;
  logic rdy_val = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s", nm);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void ref_decode(input logic [6:0] g, output logic legal,
                                     output logic [3:0] nib);
    legal = (g == 7'h00);
    nib   = 4'h0;
    for (int i = 0; i < 16; i++)
      if (GLY[i] == g) begin
        legal = 1'b1;
        nib   = i[3:0];
      end
  endfunction

  function automatic logic [6:0] pick_glyph();
    logic [6:0] g;
    logic       lg;
    logic [3:0] nb;
    int         r;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      do begin
        g = 7'($urandom);
        ref_decode(g, lg, nb);
      end while (lg);
    end else if (r == 1) begin
      g = 7'h00;
    end else begin
      g = GLY[$urandom_range(0, 15)];
    end
    return g;
  endfunction

  task automatic drive(input logic [6:0] g, input logic d);
`ifdef SEG7_ACTIVE_LOW_EN
    bus.seg_in = ~g;
`else
    bus.seg_in = g;
`endif
    bus.digit_in = d;
  endtask

  task automatic sync_pulse();
    bus.sync_in = 1'b1;
    step(2);
    bus.sync_in = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] lo_g, input logic [6:0] hi_g,
                            input logic flg, input bit expect_it);
    int         hold;
    exp_t       e;
    logic       ll, hl;
    logic [3:0] ln, hn;
    hold = $urandom_range(STABLE_CYCLES + 2, STABLE_CYCLES + 8);
    if (expect_it) begin
      ref_decode(lo_g, ll, ln);
      ref_decode(hi_g, hl, hn);
      e.data = {hn, ln};
      e.flag = flg;
      e.bad  = !(ll && hl);
      exp_q.push_back(e);
    end
    bus.flag_in = flg;
    sync_pulse();
    // Scan noise: every value lasts 2 cycles, too short to be accepted.
    for (int k = 0; k < 4; k++) begin
      drive(7'($urandom), k[0]);
      step(2);
    end
    drive(lo_g, 1'b0);
    step(hold);
    drive(hi_g, 1'b1);
    step(hold);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.frame_valid) && n < 400) begin
      step(1);
      n++;
    end
    if (n >= 400) fail({nm, "_drain_timeout"});
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"},   bus.frame_valid, 1'b0);
    chk({tag, "_data"},    bus.frame_data,  8'h00);
    chk({tag, "_flag"},    bus.frame_flag,  1'b0);
    chk({tag, "_bad"},     bus.frame_bad,   1'b0);
    chk({tag, "_overrun"}, bus.overrun,     1'b0);
    chk({tag, "_timeout"}, bus.timeout,     1'b0);
  endtask

  initial begin
    bus.frame_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.frame_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.timeout) n_tmo++;
      if (!rst && bus.frame_valid && bus.frame_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_frame");
        end else begin
          e = exp_q.pop_front();
          chk("frame_data", bus.frame_data, e.data);
          chk("frame_flag", bus.frame_flag, e.flag);
          chk("frame_bad",  bus.frame_bad,  e.bad);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic saw;
    logic [7:0] held;
    bus.seg_in = 7'h00; bus.digit_in = 1'b1; bus.sync_in = 1'b0; bus.flag_in = 1'b0;
    drive(7'h00, 1'b1);
    rst = 1'b1;
    step(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    step(5);

    // Directed frames.
    send_frame(7'h5B, 7'h4F, 1'b0, 1'b1);
    wait_drain("f32");
    send_frame(7'h7C, 7'h77, 1'b1, 1'b1);
    wait_drain("fAB");
    send_frame(7'h49, 7'h6D, 1'b0, 1'b1);
    wait_drain("fbad");
    send_frame(7'h5B, 7'h4F, 1'b0, 1'b1);
    wait_drain("fgood");

    for (int i = 0; i < 20; i++) begin
      send_frame(pick_glyph(), pick_glyph(), 1'($urandom_range(0, 1)), 1'b1);
      wait_drain("rand");
    end
    chk("no_overrun_yet", bus.overrun, 1'b0);

    // Overrun: consumer stalls while a second frame arrives.
    rdy_force = 1'b1; rdy_val = 1'b0;
    step(2);
    send_frame(7'h06, 7'h7D, 1'b1, 1'b1);
    n = 0;
    while (!bus.frame_valid && n < 20) begin step(1); n++; end
    chk("held_valid", bus.frame_valid, 1'b1);
    held = exp_q.size() > 0 ? exp_q[0].data : 8'hXX;
    send_frame(7'h3F, 7'h3F, 1'b0, 1'b0);
    chk("overrun_set", bus.overrun, 1'b1);
    chk("held_data_kept", bus.frame_data, held);
    chk("held_valid_kept", bus.frame_valid, 1'b1);
    rdy_val = 1'b1;
    wait_drain("overrun");
    step(2);
    chk("valid_dropped", bus.frame_valid, 1'b0);
    chk("overrun_sticky", bus.overrun, 1'b1);
    rdy_force = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("overrun_cleared", bus.overrun, 1'b0);

    // Timeout: low digit present but the high digit never shows.
    drive(7'h06, 1'b0);
    step(8);
    bus.sync_in = 1'b1;
    n = 0;
    saw = 1'b0;
    while (!saw && n < TIMEOUT_CYCLES + 100) begin
      step(1);
      n++;
      if (n == 2) bus.sync_in = 1'b0;
      if (bus.timeout) saw = 1'b1;
    end
    chk("timeout_seen", saw, 1'b1);
    chk("timeout_not_early", 32'(n >= TIMEOUT_CYCLES), 32'd1);
    chk("timeout_not_late", 32'(n <= TIMEOUT_CYCLES + SYNC_STAGES + 4), 32'd1);
    step(1);
    chk("timeout_one_cycle", bus.timeout, 1'b0);
    chk("timeout_no_valid", bus.frame_valid, 1'b0);

    // Fast toggling never captures; reset while waiting for the high digit.
    drive(7'h7F, 1'b1);
    step(6);
    sync_pulse();
    for (int k = 0; k < 16; k++) begin
      drive(k[0] ? 7'h5B : 7'h07, 1'b0);
      step(2);
    end
    drive(7'h7F, 1'b1);
    step(STABLE_CYCLES + 6);
    chk("toggle_no_capture", bus.frame_valid, 1'b0);
    sync_pulse();
    drive(7'h66, 1'b0);
    step(STABLE_CYCLES + 6);
    for (int k = 0; k < 6; k++) begin
      drive(k[0] ? 7'h79 : 7'h71, 1'b1);
      step(2);
    end
    rst = 1'b1;
    step(1);
    check_outputs_zero("rst_cap_hi");
    rst = 1'b0;
    drive(7'h71, 1'b1);
    step(STABLE_CYCLES + 8);
    chk("after_rst_idle", bus.frame_valid, 1'b0);

    for (int i = 0; i < 6; i++) begin
      send_frame(pick_glyph(), pick_glyph(), 1'($urandom_range(0, 1)), 1'b1);
      wait_drain("rand2");
    end
    step(4);
    chk("timeout_pulses", n_tmo, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
